// File: rtl/axi_bw_pkg.sv
// Shared types and helpers for the AXI read-bandwidth master.
//   state_t           : run-control FSM states.
//   AXI_* constants   : fixed AXI encodings used on the AR/R channels.
//   axsize()          : ARSIZE encoding for a given data-bus width.
//   exp_word()        : 32-bit test pattern word for global beat index g.
package axi_bw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  function automatic logic [2:0] axsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  // Pattern word; the full beat is this word replicated across the data bus.
  function automatic logic [31:0] exp_word(input logic [31:0] g);
    return g;
  endfunction

endpackage

// File: rtl/axi_rd_chk.sv
// R-channel checker: tracks the global beat index and the beat position inside the
// current burst, and counts data-pattern mismatches, RLAST-position errors and
// non-OKAY responses.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clear_i           : start of a new run; clears index, position and counters
//   check_en_i        : enables the data-pattern comparison
//   blen_i            : ARLEN of the bursts in this run
//   r_hs_i            : R handshake this cycle
//   rdata_i/rresp_i/rlast_i : R payload
//   err_cnt_o         : pattern mismatches plus RLAST-position errors
//   resp_err_cnt_o    : beats with RRESP != OKAY
module axi_rd_chk
  import axi_bw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned B_BURST_LENGTH = 4,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      check_en_i,
  input  logic [B_BURST_LENGTH-1:0] blen_i,
  input  logic                      r_hs_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic [1:0]                rresp_i,
  input  logic                      rlast_i,
  output logic [CNT_WIDTH-1:0]      err_cnt_o,
  output logic [CNT_WIDTH-1:0]      resp_err_cnt_o
);

  // One extra bit so a burst overrunning ARLEN is still seen as "past the end".
  localparam int unsigned BeatW = B_BURST_LENGTH + 1;
  localparam int unsigned SumW  = CNT_WIDTH + 1;

  logic [31:0]          g_q;
  logic [BeatW-1:0]     beat_q;
  logic [CNT_WIDTH-1:0] err_q, resp_err_q;

  logic [DATA_WIDTH-1:0] exp_data;
  logic                  at_last, data_err, last_err, resp_err;
  logic [SumW-1:0]       err_sum;

  assign exp_data = {(DATA_WIDTH / 32){exp_word(g_q)}};
  assign at_last  = (beat_q == BeatW'(blen_i));
  assign data_err = r_hs_i & check_en_i & (rdata_i != exp_data);
  // Covers both an early RLAST and a missing one on the final beat.
  assign last_err = r_hs_i & (rlast_i != at_last);
  assign resp_err = r_hs_i & (rresp_i != AXI_RESP_OKAY);
  // A single beat can carry both a data and a position error.
  assign err_sum  = {1'b0, err_q} + SumW'(data_err) + SumW'(last_err);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      g_q        <= '0;
      beat_q     <= '0;
      err_q      <= '0;
      resp_err_q <= '0;
    end else if (r_hs_i) begin
      g_q <= g_q + 32'd1;
      if (rlast_i) begin
        beat_q <= '0;
      end else if (!(&beat_q)) begin
        beat_q <= beat_q + BeatW'(1);
      end
      err_q <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
      if (resp_err && !(&resp_err_q)) begin
        resp_err_q <= resp_err_q + CNT_WIDTH'(1);
      end
    end
  end

  assign err_cnt_o      = err_q;
  assign resp_err_cnt_o = resp_err_q;

endmodule

// File: rtl/axi_mst_rd_bw.sv
// AXI3 read master for DDR read-bandwidth measurement. Issues NBURST INCR bursts of
// BLEN+1 beats from ADDR with at most MAX_OUTSTANDING in flight, checks the returned
// data pattern and reports cycle/beat/error counters.
//   clk, rst          : clock, synchronous active-high reset
//   m_axi_ar*         : read address channel (master side)
//   m_axi_r*          : read data channel (master side)
//   START_REG         : level; rising edge in IDLE/DONE starts a run
//   ADDR/NBURST/BLEN/CHECK_EN_REG : run configuration, latched at start
//   IDLE_REG/DONE_REG : status
//   CYCLES/BEATS/ERR/RESP_ERR_REG : saturating statistics counters
module axi_mst_rd_bw
  import axi_bw_pkg::*;
#(
  parameter int unsigned ID_WIDTH        = 6,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned B_BURST_LENGTH  = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [31:0]               m_axi_araddr,
  output logic [B_BURST_LENGTH-1:0] m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [1:0]                m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic                      START_REG,
  input  logic [31:0]               ADDR_REG,
  input  logic [31:0]               NBURST_REG,
  input  logic [B_BURST_LENGTH-1:0] BLEN_REG,
  input  logic                      CHECK_EN_REG,
  output logic                      IDLE_REG,
  output logic                      DONE_REG,
  output logic [CNT_WIDTH-1:0]      CYCLES_REG,
  output logic [CNT_WIDTH-1:0]      BEATS_REG,
  output logic [CNT_WIDTH-1:0]      ERR_REG,
  output logic [CNT_WIDTH-1:0]      RESP_ERR_REG
);

  localparam int unsigned OstW = $clog2(MAX_OUTSTANDING) + 1;

  state_t state_q, state_d;

  logic                      start_q, start_rise;
  logic [31:0]               addr_q, nburst_q, issued_q, completed_q, burst_bytes;
  logic [B_BURST_LENGTH-1:0] blen_q;
  logic                      check_en_q;
  logic [OstW-1:0]           ost_q;
  logic [CNT_WIDTH-1:0]      cycles_q, beats_q;
  logic                      ar_hs, r_hs, r_last_hs, last_ar, all_done, busy;

  // RID is not used: every burst carries ID 0 and returns in order.
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign start_rise = START_REG && !start_q && ((state_q == IDLE) || (state_q == DONE));
  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  assign r_hs       = m_axi_rvalid && m_axi_rready;
  assign r_last_hs  = r_hs && m_axi_rlast;
  assign last_ar    = ar_hs && ((issued_q + 32'd1) == nburst_q);
  // Leave DRAIN on the cycle of the final RLAST so CYCLES includes that cycle.
  assign all_done   = (completed_q + 32'(r_last_hs)) == nburst_q;
  assign burst_bytes = (32'(blen_q) + 32'd1) << axsize(DATA_WIDTH);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_rise) state_d = (NBURST_REG == 32'd0) ? DONE : RUN;
      RUN:        if (last_ar) state_d = DRAIN;
      DRAIN:      if (all_done) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Tracks START through reset too, so a level held across reset is not an edge.
  always_ff @(posedge clk) begin
    start_q <= START_REG;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      nburst_q    <= '0;
      blen_q      <= '0;
      check_en_q  <= 1'b0;
      issued_q    <= '0;
      completed_q <= '0;
      ost_q       <= '0;
      cycles_q    <= '0;
      beats_q     <= '0;
    end else if (start_rise) begin
      addr_q      <= ADDR_REG;
      nburst_q    <= NBURST_REG;
      blen_q      <= BLEN_REG;
      check_en_q  <= CHECK_EN_REG;
      issued_q    <= '0;
      completed_q <= '0;
      ost_q       <= '0;
      cycles_q    <= '0;
      beats_q     <= '0;
    end else begin
      if (ar_hs) begin
        issued_q <= issued_q + 32'd1;
        addr_q   <= addr_q + burst_bytes;
      end
      if (r_last_hs) completed_q <= completed_q + 32'd1;
      // Guard against a stray RLAST with nothing in flight.
      unique case ({ar_hs, r_last_hs && (ost_q != '0)})
        2'b10:   ost_q <= ost_q + OstW'(1);
        2'b01:   ost_q <= ost_q - OstW'(1);
        default: ost_q <= ost_q;
      endcase
      if (busy && !(&cycles_q)) cycles_q <= cycles_q + CNT_WIDTH'(1);
      if (r_hs && !(&beats_q))  beats_q  <= beats_q + CNT_WIDTH'(1);
    end
  end

  // ARVALID cannot drop before ARREADY: issued and ost only move on a handshake
  // (ost can also fall, which only keeps the request asserted).
  assign m_axi_arvalid = (state_q == RUN) && (issued_q < nburst_q) &&
                         (ost_q < OstW'(MAX_OUTSTANDING));
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = blen_q;
  // Fixed fields read as zero when no request is presented.
  assign m_axi_arsize  = m_axi_arvalid ? axsize(DATA_WIDTH) : 3'd0;
  assign m_axi_arburst = m_axi_arvalid ? AXI_BURST_INCR : 2'b00;
  assign m_axi_arcache = m_axi_arvalid ? AXI_CACHE_DEFAULT : 4'b0000;
  assign m_axi_arid    = '0;
  assign m_axi_arlock  = '0;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;
  assign m_axi_rready  = busy;

  assign IDLE_REG   = (state_q == IDLE) || (state_q == DONE);
  assign DONE_REG   = (state_q == DONE);
  assign CYCLES_REG = cycles_q;
  assign BEATS_REG  = beats_q;

  axi_rd_chk #(
    .DATA_WIDTH    (DATA_WIDTH),
    .B_BURST_LENGTH(B_BURST_LENGTH),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_chk (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (start_rise),
    .check_en_i    (check_en_q),
    .blen_i        (blen_q),
    .r_hs_i        (r_hs),
    .rdata_i       (m_axi_rdata),
    .rresp_i       (m_axi_rresp),
    .rlast_i       (m_axi_rlast),
    .err_cnt_o     (ERR_REG),
    .resp_err_cnt_o(RESP_ERR_REG)
  );

endmodule

// File: tb/tb_axi_mst_rd_bw.sv
// Scoreboard bench for axi_mst_rd_bw: a randomized AXI slave model, an expected-AR
// queue and an expected-result queue filled from a per-run arithmetic model, and a
// monitor that pops and compares on every AR handshake and every DONE rise.
module tb_axi_mst_rd_bw;

  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst, m_axi_arlock;
  logic [3:0]  m_axi_arcache, m_axi_arqos;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid, m_axi_arready;
  logic [5:0]  m_axi_rid = '0;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        START_REG = 1'b0;
  logic [31:0] ADDR_REG = '0, NBURST_REG = '0;
  logic [3:0]  BLEN_REG = '0;
  logic        CHECK_EN_REG = 1'b0;
  logic        IDLE_REG, DONE_REG;
  logic [31:0] CYCLES_REG, BEATS_REG, ERR_REG, RESP_ERR_REG;

  axi_mst_rd_bw #(
    .ID_WIDTH(6), .DATA_WIDTH(64), .B_BURST_LENGTH(4), .MAX_OUTSTANDING(MO), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .START_REG(START_REG), .ADDR_REG(ADDR_REG), .NBURST_REG(NBURST_REG),
    .BLEN_REG(BLEN_REG), .CHECK_EN_REG(CHECK_EN_REG),
    .IDLE_REG(IDLE_REG), .DONE_REG(DONE_REG), .CYCLES_REG(CYCLES_REG),
    .BEATS_REG(BEATS_REG), .ERR_REG(ERR_REG), .RESP_ERR_REG(RESP_ERR_REG)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int len; } ar_t;
  typedef struct { int beats; int err; int resp; } res_t;
  typedef struct { int len; int rdy; int idx; } bq_t;

  ar_t  exp_ar_q[$];
  res_t exp_res_q[$];
  bq_t  bq[$];

  int errors = 0, checks = 0, done_cnt = 0;
  // Slave behaviour knobs for the current run.
  int cfg_dly = 0, cfg_rdy = 100, cfg_gap = 0, cfg_bad = -1, cfg_slv = -1;
  int cfg_eb = -1, cfg_ebeat = -1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Slave: accepts ARs, returns each burst after cfg_dly cycles, in order, with the
  // index pattern and the configured faults.
  initial begin : slave
    int beat, g, bcount, scyc, ar_len;
    bit ar_hs, r_hs, rst_s, st_prev, st_rise, early;
    logic [31:0] gw;
    beat = 0; g = 0; bcount = 0; scyc = 0; st_prev = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      ar_len = int'(m_axi_arlen);
      rst_s = rst;
      st_rise = START_REG && !st_prev;
      st_prev = START_REG;
      @(posedge clk);
      #1;
      scyc++;
      if (rst_s) begin
        bq.delete(); beat = 0; g = 0; bcount = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
      end else begin
        if (st_rise) begin g = 0; bcount = 0; beat = 0; end
        if (ar_hs) begin
          bq.push_back('{len: ar_len, rdy: scyc + cfg_dly, idx: bcount});
          bcount++;
        end
        if (r_hs) begin
          g++;
          if (m_axi_rlast) begin void'(bq.pop_front()); beat = 0; end
          else beat++;
        end
        if (!(m_axi_rvalid && !r_hs)) begin
          m_axi_rvalid = 0;
          if (bq.size() > 0 && bq[0].rdy <= scyc && int'($urandom_range(99)) >= cfg_gap) begin
            early = (bq[0].idx == cfg_eb) && (beat == cfg_ebeat);
            gw = 32'(g);
            m_axi_rvalid = 1;
            m_axi_rlast  = (beat == bq[0].len) || early;
            m_axi_rdata  = {gw, gw} ^ ((g == cfg_bad) ? 64'hFF : 64'h0);
            m_axi_rresp  = (g == cfg_slv) ? 2'b10 : 2'b00;
          end
        end
      end
      m_axi_arready = (int'($urandom_range(99)) < cfg_rdy);
    end
  end

  // Monitor: AR scoreboard, in-flight limit, and end-of-run counters.
  initial begin : monitor
    int ost, cyc, last_cyc;
    bit in_run, done_prev;
    ar_t e;
    res_t r;
    ost = 0; cyc = 0; last_cyc = 0; in_run = 0; done_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ost = 0; cyc = 0; last_cyc = 0; in_run = 0; done_prev = 0;
      end else begin
        if (m_axi_arvalid && !in_run) begin in_run = 1; cyc = 0; end
        if (in_run) cyc++;
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast) last_cyc = cyc;
        if (m_axi_arvalid && m_axi_arready) begin
          check("ar_in_flight_limit", longint'(ost < MO), 1);
          if (exp_ar_q.size() == 0) begin
            check("ar_unexpected", 1, 0);
          end else begin
            e = exp_ar_q.pop_front();
            check("ar_addr", longint'(m_axi_araddr), longint'(e.addr));
            check("ar_len", longint'(m_axi_arlen), longint'(e.len));
            check("ar_fixed_fields",
                  longint'({m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid}),
                  longint'({3'd3, 2'b01, 4'b0011, 6'd0}));
          end
          ost++;
        end
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast && ost > 0) ost--;
        if (DONE_REG && !done_prev) begin
          if (exp_res_q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            r = exp_res_q.pop_front();
            check("beats", longint'(BEATS_REG), r.beats);
            check("err", longint'(ERR_REG), r.err);
            check("resp_err", longint'(RESP_ERR_REG), r.resp);
            check("cycles", longint'(CYCLES_REG), last_cyc);
            check("idle_in_done", longint'(IDLE_REG), 1);
          end
          in_run = 0; last_cyc = 0;
          done_cnt++;
        end
        done_prev = DONE_REG;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 START_REG = 1;
    repeat (2) @(posedge clk);
    #1 START_REG = 0;
  endtask

  task automatic setup(input int nb, input int bl, input logic [31:0] addr, input bit chk,
                       input int dly, input int rdy, input int gap, input int bad,
                       input int slv, input int eb, input int ebeat);
    cfg_dly = dly; cfg_rdy = rdy; cfg_gap = gap; cfg_bad = bad; cfg_slv = slv;
    cfg_eb = eb; cfg_ebeat = ebeat;
    ADDR_REG = addr; NBURST_REG = 32'(nb); BLEN_REG = 4'(bl); CHECK_EN_REG = chk;
    for (int i = 0; i < nb; i++) exp_ar_q.push_back('{addr: addr + 32'(i * (bl + 1) * 8), len: bl});
  endtask

  // Full run: the expected outcome follows from the burst count, length and fault set.
  task automatic run(input int nb, input int bl, input logic [31:0] addr, input bit chk,
                     input int dly, input int rdy, input int gap, input int bad,
                     input int slv, input int eb, input int ebeat);
    res_t r;
    int total, n0;
    setup(nb, bl, addr, chk, dly, rdy, gap, bad, slv, eb, ebeat);
    total = nb * (bl + 1);
    r.err = 0;
    if (eb >= 0) begin total -= bl - ebeat; r.err++; end
    if (chk && bad >= 0 && bad < total) r.err++;
    r.beats = total;
    r.resp = (slv >= 0 && slv < total) ? 1 : 0;
    exp_res_q.push_back(r);
    n0 = done_cnt;
    pulse_start();
    for (int c = 0; c < 5000 && done_cnt == n0; c++) @(posedge clk);
    if (done_cnt == n0) begin
      check("run_timeout", 0, 1);
      finish_now();
    end
    check("ar_queue_drained", exp_ar_q.size(), 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nb, bl, tot, bad, slv, eb, ebeat, n0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_idle", longint'(IDLE_REG), 1);
    check("rst_done", longint'(DONE_REG), 0);
    check("rst_cycles", longint'(CYCLES_REG), 0);
    check("rst_beats", longint'(BEATS_REG), 0);
    check("rst_err", longint'(ERR_REG), 0);
    check("rst_resp_err", longint'(RESP_ERR_REG), 0);
    check("rst_arvalid", longint'(m_axi_arvalid), 0);
    check("rst_rready", longint'(m_axi_rready), 0);

    run(4, 15, 32'h1000, 1, 0, 100, 0, -1, -1, -1, -1);   // basic addresses and counts
    run(4, 3, 32'h2000, 1, 20, 100, 0, -1, -1, -1, -1);   // slow R, in-flight limit
    run(2, 15, 32'h3000, 1, 0, 100, 0, 5, 9, -1, -1);     // corrupt beat 5, SLVERR beat 9
    run(2, 15, 32'h3000, 0, 0, 100, 0, 5, 9, -1, -1);     // same with check disabled
    run(2, 15, 32'h4000, 1, 0, 100, 0, -1, -1, 0, 14);    // early RLAST on beat 14

    for (int k = 0; k < 12; k++) begin
      nb = int'($urandom_range(6, 1));
      bl = int'($urandom_range(15));
      tot = nb * (bl + 1);
      bad = $urandom_range(1) ? int'($urandom_range(tot + 2)) : -1;
      slv = $urandom_range(1) ? int'($urandom_range(tot + 2)) : -1;
      eb = -1; ebeat = -1;
      if (bl > 0 && $urandom_range(3) == 0) begin
        eb = int'($urandom_range(nb - 1));
        ebeat = int'($urandom_range(bl - 1));
      end
      run(nb, bl, $urandom & 32'h0FFF_FFF8, 1'($urandom_range(1)), int'($urandom_range(20)),
          int'($urandom_range(100, 30)), int'($urandom_range(50)), bad, slv, eb, ebeat);
    end

    // Reset in DRAIN with START held high across it.
    setup(2, 15, 32'h5000, 1, 40, 100, 0, -1, -1, -1, -1);
    pulse_start();
    for (int c = 0; c < 200 && exp_ar_q.size() != 0; c++) @(posedge clk);
    check("abort_ars_issued", exp_ar_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1; START_REG = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("abort_idle", longint'(IDLE_REG), 1);
    check("abort_done", longint'(DONE_REG), 0);
    check("abort_cycles", longint'(CYCLES_REG), 0);
    check("abort_beats", longint'(BEATS_REG), 0);
    check("abort_arvalid", longint'(m_axi_arvalid), 0);
    check("abort_rready", longint'(m_axi_rready), 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_restart_on_level", longint'({IDLE_REG, m_axi_arvalid, m_axi_rready}), 4);
    end
    #1 START_REG = 0;

    // NBURST = 0: straight to DONE.
    setup(0, 3, 32'h6000, 1, 0, 100, 0, -1, -1, -1, -1);
    exp_res_q.push_back('{beats: 0, err: 0, resp: 0});
    n0 = done_cnt;
    @(posedge clk); #1 START_REG = 1;
    repeat (2) @(negedge clk);
    check("nburst0_done_in_2", longint'(done_cnt != n0), 1);
    #1 START_REG = 0;
    repeat (3) @(negedge clk);
    check("nburst0_no_ar", longint'(m_axi_arvalid), 0);

    repeat (4) @(posedge clk);
    finish_now();
  end

endmodule
